// File: rtl/memory_utils_pkg.sv
// Shared memory-side types: word type, read-type encodings, request opcodes and the
// auto-index address window used by indirect (DEFER) fetches.
package memory_utils;

  localparam int unsigned WordW = 12;
  typedef logic [WordW-1:0] word_t;

  localparam logic DataRead  = 1'b0;
  localparam logic InstrRead = 1'b1;

  typedef enum logic [1:0] {
    OpData  = 2'd0,
    OpInstr = 2'd1,
    OpWrite = 2'd2,
    OpDefer = 2'd3
  } req_op_e;

  localparam word_t AutoIdxLo = 12'o0010;
  localparam word_t AutoIdxHi = 12'o0017;

  function automatic logic is_autoindex(word_t addr);
    return (addr >= AutoIdxLo) && (addr <= AutoIdxHi);
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Per-operation wait counter: cleared on entry to a wait state, counts wait cycles and
// flags the last permitted cycle so the FSM can give up on the following edge.
module fetch_timeout_counter #(
  parameter int unsigned Limit = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Expired during the Limit-th wait cycle, so the exit edge is exactly Limit cycles in.
  assign expired_o = (cnt_q == CntW'(Limit - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/indirect_fetch_unit.sv
// CPU-side fetch unit: performs data/instruction reads, writes and indirect (DEFER)
// effective-address fetches with auto-increment, each memory wait bounded by a timeout.
module indirect_fetch_unit
  import memory_utils::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic [WordW-1:0]  req_addr,
  input  logic [WordW-1:0]  req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WordW-1:0]  rsp_data,
  output logic              rsp_error,
  output logic [WordW-1:0]  mem_address,
  output logic [WordW-1:0]  mem_write_data,
  output logic              mem_read_enable,
  output logic              mem_read_type,
  output logic              mem_write_enable,
  input  logic [WordW-1:0]  mem_read_data,
  input  logic              mem_operation_done
);

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdWait,
    StWrIssue,
    StWrWait,
    StResp
  } state_e;

  state_e  state_q, state_d;
  req_op_e op_q, op_d;
  word_t   maddr_q, maddr_d;
  word_t   mwdata_q, mwdata_d;
  word_t   rsp_data_q, rsp_data_d;
  logic    rsp_error_q, rsp_error_d;
  logic    tmo_clear, tmo_en, tmo_expired;

  fetch_timeout_counter #(
    .Limit(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .clear_i  (tmo_clear),
    .en_i     (tmo_en),
    .expired_o(tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    maddr_d     = maddr_q;
    mwdata_d    = mwdata_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    tmo_clear   = 1'b0;
    tmo_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d     = req_op_e'(req_op);
          maddr_d  = req_addr;
          mwdata_d = (req_op_e'(req_op) == OpWrite) ? req_wdata : '0;
          state_d  = (req_op_e'(req_op) == OpWrite) ? StWrIssue : StRdIssue;
        end
      end
      StRdIssue: begin
        tmo_clear = 1'b1;
        state_d   = StRdWait;
      end
      StRdWait: begin
        tmo_en = 1'b1;
        if (mem_operation_done) begin
          if (op_q == OpDefer && is_autoindex(maddr_q)) begin
            // Incremented pointer is both the write-back value and the effective address.
            mwdata_d = mem_read_data + 1'b1;
            state_d  = StWrIssue;
          end else begin
            rsp_data_d  = mem_read_data;
            rsp_error_d = 1'b0;
            state_d     = StResp;
          end
        end else if (tmo_expired) begin
          rsp_data_d  = '0;
          rsp_error_d = 1'b1;
          state_d     = StResp;
        end
      end
      StWrIssue: begin
        tmo_clear = 1'b1;
        state_d   = StWrWait;
      end
      StWrWait: begin
        tmo_en = 1'b1;
        if (mem_operation_done) begin
          rsp_data_d  = (op_q == OpDefer) ? mwdata_q : '0;
          rsp_error_d = 1'b0;
          state_d     = StResp;
        end else if (tmo_expired) begin
          rsp_data_d  = '0;
          rsp_error_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      op_q        <= OpData;
      maddr_q     <= '0;
      mwdata_q    <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      maddr_q     <= maddr_d;
      mwdata_q    <= mwdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign req_ready        = (state_q == StIdle);
  assign rsp_valid        = (state_q == StResp);
  assign rsp_data         = rsp_data_q;
  assign rsp_error        = rsp_error_q;
  assign mem_address      = maddr_q;
  assign mem_write_data   = mwdata_q;
  assign mem_read_enable  = (state_q == StRdIssue);
  assign mem_write_enable = (state_q == StWrIssue);
  assign mem_read_type    = (op_q == OpInstr) ? InstrRead : DataRead;

endmodule

// File: tb/tb_indirect_fetch_unit.sv
// Self-checking bench for indirect_fetch_unit with a behavioural memory responder
// (random latency, optional stall) and a word-level reference model of each request.
module tb_indirect_fetch_unit;
  import memory_utils::*;

  localparam int unsigned Tmo = 16;

  logic        clk, reset_n;
  logic        req_valid;
  logic [1:0]  req_op;
  word_t       req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_error;
  word_t       rsp_data, mem_address, mem_write_data, mem_read_data;
  logic        mem_read_enable, mem_read_type, mem_write_enable, mem_operation_done;

  int total = 0;
  int bad   = 0;

  indirect_fetch_unit #(
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req_valid         (req_valid),
    .req_op            (req_op),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_ready         (req_ready),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .rsp_error         (rsp_error),
    .mem_address       (mem_address),
    .mem_write_data    (mem_write_data),
    .mem_read_enable   (mem_read_enable),
    .mem_read_type     (mem_read_type),
    .mem_write_enable  (mem_write_enable),
    .mem_read_data     (mem_read_data),
    .mem_operation_done(mem_operation_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: accepts an enable pulse, completes after 0..3 extra cycles.
  word_t mem [0:4095];
  logic  stall, init_en, pending, pend_wr;
  word_t init_addr, init_val, paddr, pwdata;
  int    lat, unstable;

  initial unstable = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending            <= 1'b0;
      mem_operation_done <= 1'b0;
      mem_read_data      <= '0;
    end else begin
      mem_operation_done <= 1'b0;
      if (init_en) mem[init_addr] <= init_val;
      if (mem_read_enable || mem_write_enable) begin
        pending <= 1'b1;
        pend_wr <= mem_write_enable;
        paddr   <= mem_address;
        pwdata  <= mem_write_data;
        lat     <= $urandom_range(0, 3);
      end else if (pending && !stall) begin
        if (mem_address !== paddr || (pend_wr && mem_write_data !== pwdata))
          unstable <= unstable + 1;
        if (lat == 0) begin
          mem_operation_done <= 1'b1;
          pending            <= 1'b0;
          if (pend_wr) mem[paddr] <= pwdata;
          else mem_read_data <= mem[paddr];
        end else begin
          lat <= lat - 1;
        end
      end
    end
  end

  int   rd_pulses = 0, wr_pulses = 0, both_high = 0;
  logic last_rtype = 1'b0;
  always @(negedge clk) begin
    if (mem_read_enable) begin
      rd_pulses++;
      last_rtype = mem_read_type;
    end
    if (mem_write_enable) wr_pulses++;
    if (mem_read_enable && mem_write_enable) both_high++;
  end

  // Reference model: what each request returns and does to memory.
  word_t model_mem [0:4095];

  function automatic word_t model_op(logic [1:0] op, word_t addr, word_t wdata);
    word_t p;
    case (op)
      2'd2: begin
        model_mem[addr] = wdata;
        return '0;
      end
      2'd3: begin
        p = model_mem[addr];
        if (addr >= 12'o0010 && addr <= 12'o0017) begin
          p = p + 12'd1;
          model_mem[addr] = p;
        end
        return p;
      end
      default: return model_mem[addr];
    endcase
  endfunction

  task automatic init_mem(input word_t addr, input word_t val);
    @(negedge clk);
    init_addr = addr;
    init_val  = val;
    init_en   = 1'b1;
    model_mem[addr] = val;
    @(negedge clk);
    init_en = 1'b0;
  endtask

  task automatic do_req(input logic [1:0] op, input word_t addr, input word_t wdata,
                        output word_t data, output logic err, output logic got,
                        output logic busy_ready);
    @(negedge clk);
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    busy_ready = req_ready;
    req_valid  = 1'b0;
    req_op     = 2'($urandom);
    req_addr   = 12'($urandom);
    req_wdata  = 12'($urandom);
    got  = 1'b0;
    data = '0;
    err  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (rsp_valid) begin
        got  = 1'b1;
        data = rsp_data;
        err  = rsp_error;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    stall = 1'b0; init_en = 1'b0; init_addr = '0; init_val = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total += 8;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    if (rsp_data !== '0) begin bad++; $display("FAIL reset_rsp_data got=%o want=0", rsp_data); end
    if (rsp_error !== 1'b0) begin bad++; $display("FAIL reset_rsp_error got=%b want=0", rsp_error); end
    if (mem_address !== '0) begin bad++; $display("FAIL reset_addr got=%o want=0", mem_address); end
    if (mem_write_data !== '0) begin bad++; $display("FAIL reset_wdata got=%o want=0", mem_write_data); end
    if (mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) begin
      bad++; $display("FAIL reset_enables got=%b%b want=00", mem_read_enable, mem_write_enable);
    end
    if (mem_read_type !== DataRead) begin bad++; $display("FAIL reset_rtype got=%b want=%b", mem_read_type, DataRead); end
  endtask

  task automatic test_data_read();
    word_t d; logic e, g, br; int r0, w0;
    init_mem(12'o0200, 12'o0333);
    r0 = rd_pulses; w0 = wr_pulses;
    do_req(2'd0, 12'o0200, 12'o7070, d, e, g, br);
    total += 6;
    if (!g) begin bad++; $display("FAIL data_read_timeout got=no_rsp want=rsp"); end
    if (d !== 12'o0333 || e !== 1'b0) begin bad++; $display("FAIL data_read got=%o/%b want=0333/0", d, e); end
    if (rd_pulses - r0 != 1 || wr_pulses != w0) begin
      bad++; $display("FAIL data_read_pulses got=rd%0d/wr%0d want=1/0", rd_pulses - r0, wr_pulses - w0);
    end
    if (last_rtype !== DataRead) begin bad++; $display("FAIL data_read_type got=%b want=%b", last_rtype, DataRead); end
    if (br !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b want=0", br); end
    @(negedge clk);
    if (rsp_valid !== 1'b0 || rsp_data !== 12'o0333) begin
      bad++; $display("FAIL rsp_hold got=%b/%o want=0/0333", rsp_valid, rsp_data);
    end
    void'(model_op(2'd0, 12'o0200, '0));
  endtask

  task automatic test_write_then_read();
    word_t d; logic e, g, br; int w0;
    w0 = wr_pulses;
    do_req(2'd2, 12'o0300, 12'o4567, d, e, g, br);
    void'(model_op(2'd2, 12'o0300, 12'o4567));
    total += 3;
    if (!g || d !== '0 || e !== 1'b0) begin bad++; $display("FAIL write_rsp got=%b/%o/%b want=1/0/0", g, d, e); end
    if (wr_pulses - w0 != 1) begin bad++; $display("FAIL write_pulses got=%0d want=1", wr_pulses - w0); end
    if (mem[12'o0300] !== 12'o4567) begin bad++; $display("FAIL write_mem got=%o want=4567", mem[12'o0300]); end
    w0 = wr_pulses;
    do_req(2'd0, 12'o0300, 12'o1111, d, e, g, br);
    total += 2;
    if (!g || d !== 12'o4567 || e !== 1'b0) begin bad++; $display("FAIL readback got=%o/%b want=4567/0", d, e); end
    if (wr_pulses != w0) begin bad++; $display("FAIL readback_no_write got=%0d want=0", wr_pulses - w0); end
  endtask

  task automatic test_defer();
    word_t d; logic e, g, br; int w0;
    init_mem(12'o0010, 12'o0477);
    init_mem(12'o0020, 12'o0477);
    init_mem(12'o0017, 12'o7777);
    do_req(2'd3, 12'o0010, '0, d, e, g, br);
    void'(model_op(2'd3, 12'o0010, '0));
    total += 2;
    if (!g || d !== 12'o0500 || e) begin bad++; $display("FAIL defer_auto got=%o/%b want=0500/0", d, e); end
    if (mem[12'o0010] !== 12'o0500) begin bad++; $display("FAIL defer_auto_mem got=%o want=0500", mem[12'o0010]); end
    w0 = wr_pulses;
    do_req(2'd3, 12'o0020, '0, d, e, g, br);
    void'(model_op(2'd3, 12'o0020, '0));
    total += 3;
    if (!g || d !== 12'o0477 || e) begin bad++; $display("FAIL defer_plain got=%o/%b want=0477/0", d, e); end
    if (mem[12'o0020] !== 12'o0477) begin bad++; $display("FAIL defer_plain_mem got=%o want=0477", mem[12'o0020]); end
    if (wr_pulses != w0) begin bad++; $display("FAIL defer_plain_write got=%0d want=0", wr_pulses - w0); end
    do_req(2'd3, 12'o0017, '0, d, e, g, br);
    void'(model_op(2'd3, 12'o0017, '0));
    total += 2;
    if (!g || d !== 12'o0000 || e) begin bad++; $display("FAIL defer_wrap got=%o/%b want=0000/0", d, e); end
    if (mem[12'o0017] !== 12'o0000) begin bad++; $display("FAIL defer_wrap_mem got=%o want=0000", mem[12'o0017]); end
  endtask

  task automatic test_random_back_to_back();
    word_t d, exp_d, a, wd; logic e, g, br; logic [1:0] op; int r0, w0, er, ew;
    for (int i = 0; i < 32; i++) init_mem(12'(i), (i % 5 == 0) ? 12'o7777 : 12'($urandom));
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom);
      a  = ($urandom_range(0, 1) == 1) ? 12'(12'o0010 + $urandom_range(0, 7)) : 12'($urandom_range(0, 31));
      wd = 12'($urandom);
      er = (op != 2'd2) ? 1 : 0;
      ew = (op == 2'd2 || (op == 2'd3 && a >= 12'o0010 && a <= 12'o0017)) ? 1 : 0;
      r0 = rd_pulses; w0 = wr_pulses;
      exp_d = model_op(op, a, wd);
      do_req(op, a, wd, d, e, g, br);
      total += 3;
      if (!g || d !== exp_d || e !== 1'b0) begin
        bad++; $display("FAIL rand_rsp op=%0d addr=%o got=%b/%o/%b want=1/%o/0", op, a, g, d, e, exp_d);
      end
      if (rd_pulses - r0 != er || wr_pulses - w0 != ew) begin
        bad++; $display("FAIL rand_pulses op=%0d addr=%o got=%0d/%0d want=%0d/%0d", op, a,
                        rd_pulses - r0, wr_pulses - w0, er, ew);
      end
      if (er == 1 && last_rtype !== ((op == 2'd1) ? InstrRead : DataRead)) begin
        bad++; $display("FAIL rand_rtype op=%0d got=%b", op, last_rtype);
      end
    end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (mem[i] !== model_mem[i]) begin bad++; $display("FAIL rand_mem[%0d] got=%o want=%o", i, mem[i], model_mem[i]); end
    end
    total += 2;
    if (both_high != 0) begin bad++; $display("FAIL both_enables got=%0d want=0", both_high); end
    if (unstable != 0) begin bad++; $display("FAIL addr_stable got=%0d want=0", unstable); end
  endtask

  task automatic test_timeout();
    word_t d; logic e, g, br; int k, w0;
    stall = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd0; req_addr = 12'o0200;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 10 && !mem_read_enable; i++) @(negedge clk);
    k = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      k++;
      if (rsp_valid) break;
    end
    total += 2;
    if (k != Tmo + 1 || !rsp_valid) begin bad++; $display("FAIL timeout_cycles got=%0d want=%0d", k - 1, Tmo); end
    if (rsp_error !== 1'b1 || rsp_data !== '0) begin
      bad++; $display("FAIL timeout_rsp got=%b/%o want=1/0", rsp_error, rsp_data);
    end
    w0 = wr_pulses;
    do_req(2'd3, 12'o0012, '0, d, e, g, br);
    total += 2;
    if (!g || e !== 1'b1 || d !== '0) begin bad++; $display("FAIL defer_timeout got=%b/%b/%o want=1/1/0", g, e, d); end
    if (wr_pulses != w0) begin bad++; $display("FAIL defer_timeout_write got=%0d want=0", wr_pulses - w0); end
  endtask

  task automatic test_reset_abort();
    word_t d; logic e, g, br; int seen;
    stall = 1'b0;
    do_req(2'd0, 12'o0200, '0, d, e, g, br);
    stall = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd0; req_addr = 12'o0200;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total += 5;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL abort_ctrl got=%b/%b want=1/0", req_ready, rsp_valid);
    end
    if (rsp_data !== '0 || rsp_error !== 1'b0) begin
      bad++; $display("FAIL abort_rsp got=%o/%b want=0/0", rsp_data, rsp_error);
    end
    if (mem_address !== '0 || mem_write_data !== '0) begin
      bad++; $display("FAIL abort_mem got=%o/%o want=0/0", mem_address, mem_write_data);
    end
    if (mem_read_enable || mem_write_enable) begin bad++; $display("FAIL abort_en got=1 want=0"); end
    if (mem_read_type !== DataRead) begin bad++; $display("FAIL abort_rtype got=%b want=0", mem_read_type); end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (24) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL abort_no_rsp got=%0d want=0", seen); end
    stall = 1'b0;
    do_req(2'd0, 12'o0200, '0, d, e, g, br);
    total++;
    if (!g || d !== 12'o0333 || e) begin bad++; $display("FAIL recover got=%o/%b want=0333/0", d, e); end
  endtask

  initial begin
    test_reset();
    test_data_read();
    test_write_then_read();
    test_defer();
    test_random_back_to_back();
    test_timeout();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/indirect_fetch_unit.md
INDIRECT_FETCH_UNIT -- requirements
Module: indirect_fetch_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, max cycles waited for mem_operation_done per memory operation.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: req_valid  input  1  CPU request present.
REQ-005 Port: req_op  input  2  0=DATA read, 1=INSTRUCTION read, 2=WRITE, 3=DEFER (indirect effective address).
REQ-006 Port: req_addr  input  12  request address (word).
REQ-007 Port: req_wdata  input  12  write data for WRITE.
REQ-008 Port: req_ready  output  1  high only in IDLE.
REQ-009 Port: rsp_valid  output  1  one-cycle completion pulse.
REQ-010 Port: rsp_data  output  12  read data (reads), effective address (DEFER), 0 (WRITE).
REQ-011 Port: rsp_error  output  1  qualifies rsp_valid; timeout occurred.
REQ-012 Ports to memory controller: mem_address out 12, mem_write_data out 12, mem_read_enable out 1, mem_read_type out 1 (`DATA_READ/instruction encoding from memory_utils), mem_write_enable out 1, mem_read_data in 12, mem_operation_done in 1.

Function
REQ-013 FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP.
REQ-014 Request accepted on edge where req_valid && req_ready; req_op/addr/wdata latched; inputs ignored thereafter until IDLE.
REQ-015 Accept: reads/DEFER -> RD_ISSUE; WRITE -> WR_ISSUE.
REQ-016 RD_ISSUE lasts one cycle; mem_read_enable=1 only there; mem_read_type = instruction for op 1, `DATA_READ for ops 0 and 3.
REQ-017 WR_ISSUE lasts one cycle; mem_write_enable=1 only there; never both enables high.
REQ-018 mem_address and mem_write_data held stable from ISSUE through end of matching WAIT.
REQ-019 WAIT states exit on first cycle mem_operation_done sampled high; mem_read_data captured on that edge in RD_WAIT.
REQ-020 mem_operation_done ignored in IDLE, ISSUE and RESP.
REQ-021 DEFER: read pointer P at req_addr; if req_addr in 0010..0017 (octal) then write P+1 (mod 2^12, 7777 wraps to 0000) back to req_addr and effective address = P+1; otherwise no write, effective address = P.
REQ-022 Non-DEFER reads and plain WRITE go to RESP after single WAIT.
REQ-023 RESP lasts one cycle: rsp_valid=1, then IDLE; best case latency accept->rsp_valid = 3 cycles plus controller wait, DEFER autoindex adds WR_ISSUE+WR_WAIT.
REQ-024 Timeout counter clears on entering each WAIT, increments per WAIT cycle; reaching TIMEOUT_CYCLES -> RESP with rsp_error=1, rsp_data=0, no autoindex write.
REQ-025 rsp_data/rsp_error held after RESP until next RESP.

Reset
REQ-026 reset_n low forces IDLE immediately (mid-operation aborts, no response pulse).
REQ-027 Reset values: req_ready=1 after reset release, rsp_valid=0, rsp_data=0, rsp_error=0, mem_address=0, mem_write_data=0, both enables=0, mem_read_type=`DATA_READ, timeout counter=0.

Structure
REQ-028 Shared package (memory_utils) holds word typedef, read_type encodings, req_op enum, autoindex range constants.
REQ-029 FSM state enum local to module; single sub-module natural: fetch_timeout_counter (load/clear, expired flag).

Verification
REQ-030 Bench uses memory_controller as responder; memory preloaded via init_mem.
REQ-031 DATA read 0200 holding 0333 -> one read_enable pulse, rsp_data=0333, rsp_error=0.
REQ-032 WRITE 4567 to 0300 then DATA read 0300 -> rsp_data=4567; second op never enables write.
REQ-033 DEFER at 0010 holding 0477 -> rsp_data=0500, memory[0010]=0500 afterward; DEFER at 0020 holding 0477 -> rsp_data=0477, memory[0020] unchanged.
REQ-034 DEFER at 0017 holding 7777 -> rsp_data=0000, memory[0017]=0000.
REQ-035 Responder stubbed to never assert operation_done -> rsp_valid with rsp_error=1 exactly TIMEOUT_CYCLES cycles after RD_WAIT entry; reset_n pulsed low in RD_WAIT -> outputs at reset values, no rsp_valid.
